// File: rtl/ram_controller_ex_read_checker.sv
// Read-data checker: compares each accepted read word against per-lane 8-bit LFSR
// expected data and reports sticky per-lane status, an error count and the first bad word.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results of the last pass (if any) held
// CHECK | comparing accepted words; busy high
// DONE  | single-cycle completion; done high, pass valid
module ram_controller_ex_read_checker #(
    parameter int SEED       = 32,
    parameter int DATA_BYTES = 4,
    parameter int NUM_WORDS  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    rdata_valid,
    input  logic [8*DATA_BYTES-1:0] rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [DATA_BYTES-1:0]   pnf_per_byte,
    output logic [15:0]             err_count,
    output logic [15:0]             first_err_word
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] d);
        return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
    endfunction

    function automatic logic [8*DATA_BYTES-1:0] seed_vec();
        logic [8*DATA_BYTES-1:0] v;
        v = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            v[8*i +: 8] = 8'((SEED + i) % 256);
        end
        return v;
    endfunction

    localparam logic [8*DATA_BYTES-1:0] SEEDS    = seed_vec();
    localparam logic [15:0]             LAST_IDX = 16'(NUM_WORDS - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [8*DATA_BYTES-1:0]   lfsr_q;
    logic [8*DATA_BYTES-1:0]   lfsr_adv;
    logic [15:0]               word_idx;
    logic [DATA_BYTES-1:0]     lane_miss;
    logic [DATA_BYTES-1:0]     pnf_upd;
    logic                      accept;
    logic                      word_miss;
    logic                      last_word;
    logic                      start_pass;

    // abort wins over a coincident valid word, so that word is never counted
    assign accept     = (state == ST_CHECK) && rdata_valid && !abort;
    assign start_pass = start && (state != ST_CHECK);
    assign last_word  = accept && (word_idx == LAST_IDX);

    always_comb begin
        lane_miss = '0;
        lfsr_adv  = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            lane_miss[i]       = (rdata[8*i +: 8] != lfsr_q[8*i +: 8]);
            lfsr_adv[8*i +: 8] = lfsr_step(lfsr_q[8*i +: 8]);
        end
    end

    assign word_miss = accept && (|lane_miss);
    assign pnf_upd   = pnf_per_byte & ~(accept ? lane_miss : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (abort)          state_nxt = ST_IDLE;
                else if (last_word) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = start ? ST_CHECK : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q         <= SEEDS;
            word_idx       <= '0;
            pnf_per_byte   <= '1;
            err_count      <= '0;
            first_err_word <= 16'hFFFF;
            pass           <= 1'b0;
        end else if (start_pass) begin
            lfsr_q         <= SEEDS;
            word_idx       <= '0;
            pnf_per_byte   <= '1;
            err_count      <= '0;
            first_err_word <= 16'hFFFF;
            pass           <= 1'b0;
        end else if ((state == ST_CHECK) && abort) begin
            pass <= 1'b0;
        end else if (accept) begin
            lfsr_q       <= lfsr_adv;
            word_idx     <= word_idx + 16'd1;
            pnf_per_byte <= pnf_upd;
            if (word_miss) begin
                // err_count never wraps, so zero means no earlier mismatch this pass
                if (err_count == 16'd0) first_err_word <= word_idx;
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
            if (last_word) pass <= &pnf_upd;
        end
    end

    assign busy = (state == ST_CHECK);
    assign done = (state == ST_DONE);

endmodule

// File: doc/ram_controller_ex_read_checker.md
RAM_CONTROLLER_EX_READ_CHECKER -- requirements
Module: ram_controller_ex_read_checker

Interface
REQ-001 SHALL have parameter SEED, default 32: base LFSR seed; lane i seed = (SEED + i) mod 256.
REQ-002 SHALL have parameter DATA_BYTES, default 4: byte lanes in the read word.
REQ-003 SHALL have parameter NUM_WORDS, default 16: words checked per pass; legal range 1..65535.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse that begins a check pass.
REQ-007 abort  in  1  terminates the current pass without completion.
REQ-008 rdata_valid  in  1  qualifies rdata.
REQ-009 rdata  in  8*DATA_BYTES  read data from the memory controller; byte i = rdata[8i+7:8i].
REQ-010 busy  out  1  high while in CHECK.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 pass  out  1  pass result, held until the next start.
REQ-013 pnf_per_byte  out  DATA_BYTES  sticky per-lane pass-not-fail; 1 = no mismatch seen.
REQ-014 err_count  out  16  count of mismatching words, saturating.
REQ-015 first_err_word  out  16  index of the first mismatching word; 0xFFFF = none.

Function
REQ-016 SHALL keep one 8-bit expected-data LFSR per lane, advancing as: n0=d7, n1=d0, n2=d1^d7, n3=d2^d7, n4=d3^d7, n5=d4, n6=d5, n7=d6.
REQ-017 SHALL implement three states: IDLE, CHECK, DONE.
REQ-018 IDLE or DONE with start=1 SHALL enter CHECK and, at the same edge, load each LFSR with its seed, set pnf_per_byte to all ones, and clear err_count, word index, and pass to 0; it SHALL also set first_err_word to 0xFFFF.
REQ-019 rdata_valid SHALL be ignored outside CHECK, including the start cycle.
REQ-020 In CHECK with rdata_valid=1, SHALL compare each lane against its LFSR output at that edge and clear pnf_per_byte[i] on mismatch; then advance all LFSRs and increment the word index.
REQ-021 A word with any lane mismatching SHALL increment err_count by 1, saturating at 0xFFFF.
REQ-022 The first mismatching word of a pass SHALL latch its word index (0-based) into first_err_word; later mismatches SHALL NOT change it.
REQ-023 LFSRs and the word index SHALL hold when rdata_valid=0.
REQ-024 Acceptance of word NUM_WORDS-1 SHALL move to DONE; pass SHALL be set to the AND of the updated pnf_per_byte, including that last word, at the same edge.
REQ-025 done SHALL equal (state==DONE); DONE SHALL last exactly one cycle and then go to IDLE unless start=1.
REQ-026 start in CHECK SHALL be ignored.
REQ-027 abort in CHECK SHALL go to IDLE with no done pulse and pass=0; the counters and pnf_per_byte SHALL hold their values.
REQ-028 abort and rdata_valid in the same cycle: abort SHALL take priority and the word SHALL NOT be counted.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 Output latency: status SHALL reflect a word one cycle after the edge at which it is accepted, registered with no combinational path from input to output.

Reset
REQ-031 While reset_n=0: state SHALL be IDLE; busy, done, pass and err_count SHALL be 0; pnf_per_byte SHALL be all ones; first_err_word SHALL be 0xFFFF; LFSRs SHALL hold their seeds; word index SHALL be 0.
REQ-032 Reset asserted mid-pass SHALL abandon the pass immediately with no done pulse.

Verification
REQ-033 Clean pass: SEED=32, DATA_BYTES=2, NUM_WORDS=4, start, feed lane0 0x20,0x40,0x80,0x1D and lane1 0x21,0x42,0x84,0x15 -> done pulses once, pass=1, err_count=0, first_err_word=0xFFFF.
REQ-034 Single error: same setup as REQ-033 with word 2 lane1=0x00 -> pnf_per_byte=2'b01, err_count=1, first_err_word=2, pass=0.
REQ-035 Gapped valid: same data as REQ-033 with rdata_valid low 3 cycles between words -> result identical to REQ-033; busy high throughout.
REQ-036 Abort: after 2 words, abort together with valid word 3 -> no done, busy=0, err_count unchanged, the word is not counted.
REQ-037 Saturation: NUM_WORDS=65535 with all words wrong -> err_count=0xFFFF, first_err_word=0.
REQ-038 Restart and reset: start in DONE -> fresh pass with counters cleared; reset_n low during CHECK -> all outputs at reset values on the next cycle.
